// File: rtl/operand_fetch_if.sv
// Bundle of the operand-fetch stage's handshake, register-file and writeback signals.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface operand_fetch_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic [AW-1:0] rf_rs;
  logic [AW-1:0] rf_rt;
  logic [DW-1:0] rf_rs_o;
  logic [DW-1:0] rf_rt_o;
  logic          rf_write;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_rd_i;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_op;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [AW-1:0] out_dest;
  logic          out_wen;
  logic [DW-1:0] out_imm;

  modport master (
    output in_valid, instr, rf_rs_o, rf_rt_o, wb_valid, wb_rd, wb_data, out_ready,
    input  in_ready, rf_rs, rf_rt, rf_write, rf_rd, rf_rd_i,
           out_valid, out_op, out_a, out_b, out_dest, out_wen, out_imm
  );

  modport slave (
    input  in_valid, instr, rf_rs_o, rf_rt_o, wb_valid, wb_rd, wb_data, out_ready,
    output in_ready, rf_rs, rf_rt, rf_write, rf_rd, rf_rd_i,
           out_valid, out_op, out_a, out_b, out_dest, out_wen, out_imm
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: scoreboarded RAW/WAW stall, writeback forwarding,
// and a one-entry ID/EX output register with valid/ready backpressure.
module operand_fetch #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input logic           clk,
  input logic           reset,
  operand_fetch_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  logic [NREGS-1:0] sb_r;
  logic [NREGS-1:0] wb_hit_s;
  logic [NREGS-1:0] sb_set_s;
  logic [NREGS-1:0] pending_s;
  logic [5:0]       op_s;
  logic [AW-1:0]    rs_s;
  logic [AW-1:0]    rt_s;
  logic [AW-1:0]    rd_s;
  logic [AW-1:0]    dest_s;
  logic             wen_s;
  logic             hazard_s;
  logic             in_ready_s;
  logic             fire_s;
  logic [DW-1:0]    opa_s;
  logic [DW-1:0]    opb_s;
  logic [DW-1:0]    imm_s;
  logic [5:0]       op_r;
  logic [DW-1:0]    a_r;
  logic [DW-1:0]    b_r;
  logic [AW-1:0]    dest_r;
  logic             wen_r;
  logic [DW-1:0]    imm_r;

  assign op_s  = bus.instr[31:26];
  assign rs_s  = bus.instr[25:21];
  assign rt_s  = bus.instr[20:16];
  assign rd_s  = bus.instr[15:11];
  assign imm_s = {{(DW-16){bus.instr[15]}}, bus.instr[15:0]};

  // Destination decode: R-type writes rd, immediate ALU ops and lw write rt.
  always_comb begin
    wen_s  = 1'b0;
    dest_s = {AW{1'b0}};
    if (op_s == 6'h00) begin
      wen_s  = 1'b1;
      dest_s = rd_s;
    end else if ((op_s[5:3] == 3'b001) || (op_s == 6'h23)) begin
      wen_s  = 1'b1;
      dest_s = rt_s;
    end else begin
      wen_s  = 1'b0;
      dest_s = {AW{1'b0}};
    end
  end

  // A writeback retiring this cycle releases its register immediately.
  assign wb_hit_s  = bus.wb_valid ? ({{(NREGS-1){1'b0}}, 1'b1} << bus.wb_rd) : {NREGS{1'b0}};
  assign pending_s = sb_r & ~wb_hit_s;
  assign sb_set_s  = (fire_s & wen_s) ? ({{(NREGS-1){1'b0}}, 1'b1} << dest_s) : {NREGS{1'b0}};

  assign hazard_s   = pending_s[rs_s] | pending_s[rt_s] | (wen_s & pending_s[dest_s]);
  assign in_ready_s = ~hazard_s & ((state_r == EMPTY) | bus.out_ready);
  assign fire_s     = bus.in_valid & in_ready_s;

  assign opa_s = (bus.wb_valid && (bus.wb_rd == rs_s)) ? bus.wb_data : bus.rf_rs_o;
  assign opb_s = (bus.wb_valid && (bus.wb_rd == rt_s)) ? bus.wb_data : bus.rf_rt_o;

  assign bus.in_ready  = in_ready_s;
  assign bus.rf_rs     = rs_s;
  assign bus.rf_rt     = rt_s;
  assign bus.rf_write  = bus.wb_valid;
  assign bus.rf_rd     = bus.wb_rd;
  assign bus.rf_rd_i   = bus.wb_data;
  assign bus.out_valid = (state_r == FULL);
  assign bus.out_op    = op_r;
  assign bus.out_a     = a_r;
  assign bus.out_b     = b_r;
  assign bus.out_dest  = dest_r;
  assign bus.out_wen   = wen_r;
  assign bus.out_imm   = imm_r;

  // Scoreboard: a same-edge set on a register being written back wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_r <= {NREGS{1'b0}};
    end else begin
      sb_r <= pending_s | sb_set_s;
    end
  end

  // ID/EX output register and its occupancy FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= EMPTY;
      op_r    <= 6'd0;
      a_r     <= {DW{1'b0}};
      b_r     <= {DW{1'b0}};
      dest_r  <= {AW{1'b0}};
      wen_r   <= 1'b0;
      imm_r   <= {DW{1'b0}};
    end else begin
      if (fire_s) begin
        op_r   <= op_s;
        a_r    <= opa_s;
        b_r    <= opb_s;
        dest_r <= dest_s;
        wen_r  <= wen_s;
        imm_r  <= imm_s;
      end
      case (state_r)
        EMPTY: begin
          if (fire_s) state_r <= FULL;
          else        state_r <= EMPTY;
        end
        FULL: begin
          if (fire_s)             state_r <= FULL;
          else if (bus.out_ready) state_r <= EMPTY;
          else                    state_r <= FULL;
        end
        default: state_r <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file environment, directed hazard scenarios and
// randomized traffic checked against a set-based pending-register model.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  operand_fetch_if #(.DW(32), .AW(5)) bus ();

  operand_fetch #(.NREGS(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment register file: combinational read, written through the stage's write port.
  logic [31:0] rf_mem [32];
  assign bus.rf_rs_o = rf_mem[bus.rf_rs];
  assign bus.rf_rt_o = rf_mem[bus.rf_rt];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
    end else if (bus.rf_write) begin
      rf_mem[bus.rf_rd] <= bus.rf_rd_i;
    end
  end

  // Reference state: set of pending registers, architectural register values, ID/EX contents.
  bit          pend [32];
  logic [31:0] ref_rf [32];
  bit          m_ov;
  logic [5:0]  m_op;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_dest;
  bit          m_wen;
  logic [5:0]  ops [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pe(input logic [4:0] r);
    return pend[r] && !(bus.wb_valid && (bus.wb_rd == r));
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      pend[i]   = 1'b0;
      ref_rf[i] = 32'd0;
    end
    m_ov = 1'b0;
  endtask

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.out_ready = 1'b1;
  endtask

  // One clock: inputs already driven after a negedge; returns at the next negedge.
  task automatic step();
    logic [5:0]  op;
    logic [4:0]  rs, rt, dst, wbr;
    logic [31:0] a, b;
    bit          wen, hz, rdy, fire;
    #1;
    op   = bus.instr[31:26];
    rs   = bus.instr[25:21];
    rt   = bus.instr[20:16];
    wen  = (op == 6'h00) || (op[5:3] == 3'b001) || (op == 6'h23);
    dst  = !wen ? 5'd0 : ((op == 6'h00) ? bus.instr[15:11] : rt);
    hz   = pe(rs) || pe(rt) || (wen && pe(dst));
    rdy  = !hz && (!m_ov || bus.out_ready);
    check_val("in_ready", 32'(bus.in_ready), 32'(rdy));
    fire = bus.in_valid && rdy;
    a = (bus.wb_valid && (bus.wb_rd == rs)) ? bus.wb_data : ref_rf[rs];
    b = (bus.wb_valid && (bus.wb_rd == rt)) ? bus.wb_data : ref_rf[rt];
    if (fire) begin
      m_ov = 1'b1; m_op = op; m_a = a; m_b = b; m_dest = dst; m_wen = wen;
      m_imm = {{16{bus.instr[15]}}, bus.instr[15:0]};
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    wbr = bus.wb_rd;
    if (bus.wb_valid) begin
      pend[wbr]   = 1'b0;
      ref_rf[wbr] = bus.wb_data;
    end
    if (fire && wen) pend[dst] = 1'b1;
    @(posedge clk);
    #1;
    check_val("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      check_val("out_op", 32'(bus.out_op), 32'(m_op));
      check_val("out_a", bus.out_a, m_a);
      check_val("out_b", bus.out_b, m_b);
      check_val("out_dest", 32'(bus.out_dest), 32'(m_dest));
      check_val("out_wen", 32'(bus.out_wen), 32'(m_wen));
      check_val("out_imm", bus.out_imm, m_imm);
    end
    check_val("rf_word", rf_mem[wbr], ref_rf[wbr]);
    @(negedge clk);
  endtask

  // Reset asserted between edges must clear the stage before any clock arrives.
  task automatic do_reset();
    bus.wb_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rel_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic retire(input logic [4:0] r);
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    bus.wb_data  = $urandom;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held_a;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h3F};
    set_idle();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Forwarding of a same-cycle writeback into operand A and into the RF.
    bus.in_valid = 1'b1;
    bus.instr    = mk_i(6'h08, 5'd3, 5'd9, 16'h0001);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hAAAA_AAAA;
    step();
    check_val("fwd_out_a", bus.out_a, 32'hAAAA_AAAA);
    check_val("fwd_rf3", rf_mem[3], 32'hAAAA_AAAA);
    retire(5'd9);

    // RAW: second instruction reads rt=4 produced by the first.
    bus.in_valid = 1'b1;
    bus.instr    = mk_r(6'h00, 5'd1, 5'd2, 5'd4);
    step();
    bus.instr = mk_r(6'h00, 5'd6, 5'd4, 5'd7);
    #1;
    check_val("raw_stall", 32'(bus.in_ready), 32'd0);
    step();
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    bus.wb_data  = 32'h1234_5678;
    step();
    check_val("raw_out_b", bus.out_b, 32'h1234_5678);
    retire(5'd7);

    // WAW: lw to r5 waits for the in-flight addi to r5, then re-marks r5 pending.
    bus.in_valid = 1'b1;
    bus.instr    = mk_i(6'h08, 5'd1, 5'd5, 16'h0010);
    step();
    bus.instr = mk_i(6'h23, 5'd2, 5'd5, 16'h0020);
    #1;
    check_val("waw_stall", 32'(bus.in_ready), 32'd0);
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'h0000_0555;
    step();
    bus.wb_valid = 1'b0;
    bus.instr    = mk_r(6'h00, 5'd5, 5'd0, 5'd8);
    #1;
    check_val("waw_sb_kept", 32'(bus.in_ready), 32'd0);
    step();
    retire(5'd5);
    retire(5'd8);

    // Backpressure: held outputs, then a bubble-free back-to-back transfer.
    bus.in_valid  = 1'b1;
    bus.instr     = mk_r(6'h00, 5'd1, 5'd2, 5'd10);
    step();
    held_a        = bus.out_a;
    bus.out_ready = 1'b0;
    bus.instr     = mk_r(6'h00, 5'd3, 5'd6, 5'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_hold_dest", 32'(bus.out_dest), 32'd10);
      check_val("bp_hold_a", bus.out_a, held_a);
    end
    bus.out_ready = 1'b1;
    step();
    check_val("b2b_dest", 32'(bus.out_dest), 32'd11);
    retire(5'd10);
    retire(5'd11);

    // Non-writers: sw and beq leave the scoreboard alone; imm is sign-extended.
    bus.in_valid = 1'b1;
    bus.instr    = mk_i(6'h2B, 5'd1, 5'd2, 16'h8000);
    step();
    check_val("sw_wen", 32'(bus.out_wen), 32'd0);
    check_val("sw_imm", bus.out_imm, 32'hFFFF_8000);
    bus.instr = mk_i(6'h04, 5'd2, 5'd1, 16'h0004);
    #1;
    check_val("beq_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_val("beq_wen", 32'(bus.out_wen), 32'd0);

    // Reset in the middle of a stall with a full output register.
    bus.instr = mk_r(6'h00, 5'd1, 5'd2, 5'd12);
    step();
    bus.out_ready = 1'b0;
    bus.instr     = mk_r(6'h00, 5'd12, 5'd2, 5'd13);
    step();
    do_reset();
    set_idle();

    // Randomized traffic on a small register window to provoke frequent hazards.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.instr         = $urandom;
      bus.instr[31:26]  = ops[$urandom_range(0, 7)];
      bus.instr[25:21]  = 5'($urandom_range(0, 7));
      bus.instr[20:16]  = 5'($urandom_range(0, 7));
      bus.instr[15:11]  = 5'($urandom_range(0, 7));
      bus.wb_valid      = ($urandom_range(0, 1) == 1);
      bus.wb_rd         = 5'($urandom_range(0, 7));
      bus.wb_data       = $urandom;
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
